// File: rtl/riscv_defines.sv
// Shared RISC-V execute-stage definitions: operation classes, ALU controls
// and the iteration count of the shift-add multiplier.
package riscv_defines;

    localparam int unsigned XLEN            = 32;
    localparam int unsigned MUL_SHIFT_COUNT = 32;
    localparam int unsigned MUL_CNT_W       = $clog2(MUL_SHIFT_COUNT);

    typedef enum logic [2:0] {
        ALUOP_ALU    = 3'd0,
        ALUOP_BRANCH = 3'd1,
        ALUOP_LOAD   = 3'd2,
        ALUOP_STORE  = 3'd3,
        ALUOP_MUL    = 3'd4,
        ALUOP_DIV    = 3'd5
    } aluop_t;

    typedef enum logic [4:0] {
        ALU_ADD    = 5'd0,
        ALU_SUB    = 5'd1,
        ALU_AND    = 5'd2,
        ALU_OR     = 5'd3,
        ALU_XOR    = 5'd4,
        ALU_SLL    = 5'd5,
        ALU_SRL    = 5'd6,
        ALU_SRA    = 5'd7,
        ALU_SLT    = 5'd8,
        ALU_SLTU   = 5'd9,
        ALU_MUL    = 5'd16,
        ALU_MULH   = 5'd17,
        ALU_MULHSU = 5'd18,
        ALU_MULHU  = 5'd19
    } alucontrol_t;

endpackage

// File: rtl/exec_multiplier.sv
// Iterative radix-2 shift-add multiplier for the RV32M MUL/MULH/MULHSU/MULHU
// group: sign/magnitude operands, 32 add-shift steps, one-cycle valid pulse.
module exec_multiplier
    import riscv_defines::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        ex_fire,
    input  aluop_t      aluop,
    input  alucontrol_t alucontrol,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic        mul_busy,
    output logic        mul_valid,
    output logic [31:0] mulresult
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FINAL = 2'd2
    } mul_state_t;

    mul_state_t            state_q, state_d;
    logic [MUL_CNT_W-1:0]  cnt_q, cnt_d;
    logic [2*XLEN-1:0]     acc_q, acc_d;
    logic [XLEN-1:0]       mcand_q, mcand_d;
    logic [XLEN-1:0]       mplier_q, mplier_d;
    logic                  sign_q, sign_d;
    alucontrol_t           op_q, op_d;
    logic                  valid_d;
    logic [XLEN-1:0]       result_d;

    logic                  launch_c;
    logic                  a_signed_c, b_signed_c;
    logic                  a_neg_c, b_neg_c;
    logic [XLEN-1:0]       mag_a_c, mag_b_c;
    logic [XLEN:0]         sum_c;
    logic [2*XLEN-1:0]     product_c;
    logic [XLEN-1:0]       select_c;

    assign launch_c = ex_fire && (aluop == ALUOP_MUL);

    // Operand signedness and magnitudes; 0x80000000 maps onto itself as unsigned.
    always_comb begin
        a_signed_c = (alucontrol != ALU_MULHU);
        b_signed_c = (alucontrol == ALU_MUL) || (alucontrol == ALU_MULH);
        a_neg_c    = a_signed_c && in_a[XLEN-1];
        b_neg_c    = b_signed_c && in_b[XLEN-1];
        mag_a_c    = a_neg_c ? XLEN'(~in_a + XLEN'(1)) : in_a;
        mag_b_c    = b_neg_c ? XLEN'(~in_b + XLEN'(1)) : in_b;
    end

    // One partial-product step; the 33-bit sum keeps the carry into the shift.
    assign sum_c = {1'b0, acc_q[2*XLEN-1:XLEN]}
                 + (mplier_q[0] ? {1'b0, mcand_q} : (XLEN+1)'(0));

    // Sign is applied once, on the finished magnitude product.
    always_comb begin
        product_c = sign_q ? (2*XLEN)'(~acc_q + (2*XLEN)'(1)) : acc_q;
        select_c  = (op_q == ALU_MUL) ? product_c[XLEN-1:0]
                                      : product_c[2*XLEN-1:XLEN];
    end

    // Next-state and datapath update.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        sign_d   = sign_q;
        op_d     = op_q;
        valid_d  = 1'b0;
        result_d = mulresult;

        if (flush) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            acc_d   = '0;
        end else if (launch_c) begin
            state_d  = ST_BUSY;
            cnt_d    = '0;
            acc_d    = '0;
            mcand_d  = mag_a_c;
            mplier_d = mag_b_c;
            sign_d   = a_neg_c ^ b_neg_c;
            op_d     = alucontrol;
        end else begin
            case (state_q)
                ST_BUSY: begin
                    acc_d    = {sum_c, acc_q[XLEN-1:1]};
                    mplier_d = {1'b0, mplier_q[XLEN-1:1]};
                    if (cnt_q == MUL_CNT_W'(MUL_SHIFT_COUNT - 1)) begin
                        state_d = ST_FINAL;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = MUL_CNT_W'(cnt_q + MUL_CNT_W'(1));
                    end
                end
                ST_FINAL: begin
                    state_d  = ST_IDLE;
                    valid_d  = 1'b1;
                    result_d = select_c;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            sign_q    <= 1'b0;
            op_q      <= ALU_MUL;
            mul_busy  <= 1'b0;
            mul_valid <= 1'b0;
            mulresult <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            sign_q    <= sign_d;
            op_q      <= op_d;
            mul_busy  <= (state_d == ST_BUSY);
            mul_valid <= valid_d;
            mulresult <= result_d;
        end
    end

endmodule

// File: doc/exec_multiplier.md
EXEC_MULTIPLIER -- requirements
Module: exec_multiplier

Interface
REQ-001 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-003 SHALL have port flush  input  1  pipeline flush; abandons any operation in flight.
REQ-004 SHALL have port ex_fire  input  1  execute-stage accept strobe; an operation is launched when ex_fire=1 and aluop=ALUOP_MUL.
REQ-005 SHALL have port aluop  input  aluop_t  operation class from riscv_defines.
REQ-006 SHALL have port alucontrol  input  alucontrol_t  one of ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU.
REQ-007 SHALL have ports in_a and in_b  input  32 each  operands rs1 and rs2.
REQ-008 SHALL have port mul_busy  output  1  high while iterations are in progress.
REQ-009 SHALL have port mul_valid  output  1  one-cycle pulse marking mulresult as final.
REQ-010 SHALL have port mulresult  output  32  selected product word.

Function
REQ-011 SHALL implement a radix-2 shift-add multiplier, one partial-product step per clk, MUL_SHIFT_COUNT=32 steps.
REQ-012 SHALL, at the launch edge, latch alucontrol, the magnitude operands, the product sign and the 64-bit accumulator (cleared), then set mul_busy=1 and mul_valid=0.
REQ-013 SHALL derive signedness as follows: MULH treats both operands as signed; MULHSU treats in_a as signed and in_b as unsigned; MULHU treats both as unsigned; MUL treats both as signed (low word is sign-invariant).
REQ-014 SHALL use the two's-complement magnitude for each signed operand; the magnitude of 0x80000000 SHALL be 0x80000000, treated as unsigned.
REQ-015 SHALL set product sign = (a signed & in_a[31]) XOR (b signed & in_b[31]), and apply the 64-bit negation once, at result selection.
REQ-016 SHALL, on each busy edge, add the multiplicand to the upper accumulator when the current multiplier LSB=1 (33-bit sum keeps the carry), then shift accumulator and multiplier right by one.
REQ-017 SHALL, on busy step 32 (counter = MUL_SHIFT_COUNT-1), clear mul_busy, reset the counter and assert mul_valid for exactly the following cycle.
REQ-018 SHALL make the latency exactly 33 clk edges from the launch edge to the mul_valid cycle.
REQ-019 SHALL select the output from the latched op: MUL gives signed product[31:0]; MULH, MULHSU and MULHU give signed product[63:32].
REQ-020 SHALL hold mulresult stable from the mul_valid cycle until the next launch, and keep it independent of the live alucontrol.
REQ-021 SHALL give flush priority over launch and iteration; on flush, mul_busy=0, mul_valid=0, the counter is cleared and the accumulator is cleared.
REQ-022 SHALL let a launch while busy, without flush, restart the operation with the new operands, discard the old one, and produce no mul_valid for it.
REQ-023 SHALL produce mul_valid=0 in every cycle not described in REQ-017.
REQ-024 SHALL produce 0 for a zero operand, with the same 33-cycle latency and no early termination.

Reset
REQ-025 SHALL, when rst=1 at a clk edge, force mul_busy=0, mul_valid=0, counter=0, accumulator=0, latched operands=0, sign=0 and latched op=ALU_MUL.
REQ-026 SHALL give rst priority over flush and ex_fire; a reset mid-operation discards the operation with no mul_valid.
REQ-027 SHALL make mulresult read 0 after reset, until the first completion.

Structure
REQ-028 SHALL place MUL_SHIFT_COUNT in riscv_defines, alongside the existing ALUOP_MUL and ALU_MUL* enumerators; no new local typedefs.
REQ-029 SHALL be a single module with no sub-module; the sign/magnitude logic is inline combinational.

Verification
REQ-030 SHALL cover: MUL in_a=7, in_b=0xFFFFFFFD -> mulresult=0xFFFFFFEB, mul_valid exactly 33 edges after launch, for one cycle.
REQ-031 SHALL cover: MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
REQ-032 SHALL cover: MULHSU in_a=0xFFFFFFFF (-1), in_b=0xFFFFFFFF -> 0xFFFFFFFF; MUL of the same operands -> 0x00000001.
REQ-033 SHALL cover: flush on busy step 10 -> mul_busy=0 next cycle, no mul_valid; a following MULHU 3 x 5 -> 0x00000000 and MUL -> 0x0000000F.
REQ-034 SHALL cover: rst on busy step 20 -> all outputs 0 next cycle, no mul_valid; a relaunch while busy (MUL 6x7 at step 5) -> single mul_valid 33 edges later with 0x0000002A.
REQ-035 SHALL cover: random self-checking MUL, MULH, MULHSU and MULHU against a 64-bit reference model, with alucontrol toggled during busy having no effect.
